// File: rtl/data_sram_responder_pkg.sv
// Shared constants for the data-memory responder: size codes, request bundle
// layout and the data width.
package data_sram_responder_pkg;

    localparam int DATA_W = 32;
    localparam int BYTES  = DATA_W / 8;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Request bundle, MSB first: wr, size, addr, wstrb, wdata.
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [31:0]       addr;
        logic [BYTES-1:0]  wstrb;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    localparam int REQ_W = $bits(mem_req_t);

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BYTES-1:0]  strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BYTES; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_responder_queue.sv
// In-order response FIFO of {data, timer}; each valid entry's timer counts
// down to zero and the head may leave once its timer has expired.
module resp_queue #(
    parameter int DEPTH   = 2,
    parameter int DATA_W  = 32,
    parameter int TIMER_W = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_data,
    input  logic [TIMER_W-1:0] push_timer,
    input  logic               pop,
    output logic               head_ready,
    output logic [DATA_W-1:0]  head_data,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic [TIMER_W-1:0] timer_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign head_ready = ~empty & (timer_q[head] == '0);
    assign head_data  = data_q[head];
    assign do_push    = push & ~full;
    assign do_pop     = pop & head_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && timer_q[i] != '0) timer_q[i] <= timer_q[i] - 1'b1;
            end
            // push never targets the popped slot: that needs full or empty
            if (do_push) begin
                data_q[tail]  <= push_data;
                timer_q[tail] <= push_timer;
                valid_q[tail] <= 1'b1;
                tail          <= next_ptr(tail);
            end
            if (do_pop) begin
                valid_q[head] <= 1'b0;
                head          <= next_ptr(head);
            end
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-memory endpoint: word RAM accessed at acceptance, responses returned
// in order after READ_LATENCY through a bounded outstanding queue.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int DEPTH        = 2,
    parameter int ACCEPT_GAP   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [BYTES-1:0]  wstrb,
    input  logic [DATA_W-1:0] wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata
);
    localparam int TIMER_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int GAP_W   = (ACCEPT_GAP > 0) ? $clog2(ACCEPT_GAP + 1) : 1;

    logic [DATA_W-1:0]     mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  accept;
    logic                  q_full;
    logic                  q_empty;
    logic                  head_ready;
    logic [DATA_W-1:0]     head_data;
    logic [DATA_W-1:0]     push_data;
    logic                  unused;

    // byte offset and address bits above the RAM are intentionally dropped
    assign idx    = addr[ADDR_WIDTH+1:2];
    assign unused = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0], q_empty};

    assign addr_ok   = ~reset & ~q_full & (gap_cnt == '0);
    assign accept    = req & addr_ok;
    assign data_ok   = ~reset & head_ready;
    assign rdata     = data_ok ? head_data : '0;
    assign push_data = wr ? '0 : mem[idx];

    always_ff @(posedge clk) begin
        if (accept && wr) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
    end

    always_ff @(posedge clk) begin
        if (reset)                gap_cnt <= '0;
        else if (accept)          gap_cnt <= GAP_W'(ACCEPT_GAP);
        else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
    end

    resp_queue #(
        .DEPTH   (DEPTH),
        .DATA_W  (DATA_W),
        .TIMER_W (TIMER_W)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_data  (push_data),
        .push_timer (TIMER_W'(READ_LATENCY - 1)),
        .pop        (data_ok),
        .head_ready (head_ready),
        .head_data  (head_data),
        .full       (q_full),
        .empty      (q_empty)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: three responders (default, latency 4, accept gap 2)
// share one request bus; each has its own req and expected-response queue.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [31:0] addr = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  aok;
    logic [2:0]  dok;
    logic [31:0] rd [3];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mdl  [3][1024];
    logic [31:0] expq [3][$];
    int          accq [3][$];
    logic [31:0] mon_e;
    int          mon_a;
    logic [9:0]  mon_idx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_responder u_a (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]));

    data_sram_responder #(.READ_LATENCY(4), .DEPTH(2)) u_b (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]));

    data_sram_responder #(.ACCEPT_GAP(2)) u_c (
        .clk(clk), .reset(reset), .req(req[2]), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd[2]));

    function automatic int lat_of(input int i);
        return (i == 1) ? 4 : 1;
    endfunction

    // Response check happens before logging the acceptance about to occur.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dok[i]) begin
                checks++;
                if (expq[i].size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected inst=%0d rdata=%h", i, rd[i]);
                end else begin
                    mon_e = expq[i].pop_front();
                    mon_a = accq[i].pop_front();
                    if (rd[i] !== mon_e || (cyc - mon_a) < lat_of(i)) begin
                        failures++;
                        $display("FAIL resp_data inst=%0d got=%h exp=%h latency=%0d min=%0d",
                                 i, rd[i], mon_e, cyc - mon_a, lat_of(i));
                    end
                end
            end
            if (!reset && req[i] && aok[i]) begin
                mon_idx = addr[11:2];
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mdl[i][mon_idx][8*b +: 8] = wdata[8*b +: 8];
                    expq[i].push_back(32'h0);
                end else begin
                    expq[i].push_back(mdl[i][mon_idx]);
                end
                accq[i].push_back(cyc);
            end
        end
    end

    task automatic send(input int i, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        wr = w; addr = a; wstrb = s; wdata = d; req[i] = 1'b1;
        @(negedge clk);
        while (!aok[i] && n < 50) begin @(negedge clk); n++; end
        if (!aok[i]) begin
            checks++; failures++;
            $display("FAIL accept_timeout inst=%0d addr=%h", i, a);
        end
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (aok !== 3'b000 || dok !== 3'b000 || rd[0] !== 0 || rd[1] !== 0 || rd[2] !== 0) begin
            failures++;
            $display("FAIL reset_outputs addr_ok=%b data_ok=%b exp=000/000", aok, dok);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (aok !== 3'b111 || dok !== 3'b000) begin
            failures++;
            $display("FAIL post_reset addr_ok=%b data_ok=%b exp=111/000", aok, dok);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        req[0] = 1'b1; wr = 1'b1; addr = 32'h10; wstrb = 4'hF; wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (aok[0] !== 1'b1) begin failures++; $display("FAIL basic_store_aok got=%b exp=1", aok[0]); end
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        checks++;
        if (aok[0] !== 1'b1) begin failures++; $display("FAIL basic_load_aok got=%b exp=1", aok[0]); end
        checks++;
        if (dok[0] !== 1'b1 || rd[0] !== 32'h0) begin
            failures++; $display("FAIL basic_store_resp data_ok=%b rdata=%h exp=1/0", dok[0], rd[0]);
        end
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (dok[0] !== 1'b1 || rd[0] !== 32'h12345678) begin
            failures++; $display("FAIL basic_load_resp data_ok=%b rdata=%h exp=1/12345678", dok[0], rd[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_merge;
        send(0, 1'b1, 32'h10, 4'b0100, 32'hAABBCCDD);
        send(0, 1'b0, 32'h12, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (dok[0] !== 1'b1 || rd[0] !== 32'h12BB5678) begin
            failures++; $display("FAIL byte_merge data_ok=%b rdata=%h exp=1/12bb5678", dok[0], rd[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        send(0, 1'b0, 32'h1000_0010, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (dok[0] !== 1'b1 || rd[0] !== 32'h12BB5678) begin
            failures++; $display("FAIL addr_wrap data_ok=%b rdata=%h exp=1/12bb5678", dok[0], rd[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_aok = 8'b0110_0011;
        logic [7:0] exp_dok = 8'b0011_0000;
        send(1, 1'b1, 32'h4, 4'hF, 32'h0BADBEEF);
        repeat (6) @(posedge clk);
        #1;
        req[1] = 1'b1; wr = 1'b0; addr = 32'h4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (aok[1] !== exp_aok[k] || dok[1] !== exp_dok[k]) begin
                failures++;
                $display("FAIL backpressure cycle=%0d addr_ok=%b data_ok=%b exp=%b/%b",
                         k, aok[1], dok[1], exp_aok[k], exp_dok[k]);
            end
            @(posedge clk); #1;
        end
        req[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_gap;
        logic [5:0] exp_aok = 6'b001001;
        logic [5:0] exp_dok = 6'b010010;
        send(2, 1'b1, 32'h20, 4'hF, 32'h55AA33CC);
        repeat (4) @(posedge clk);
        #1;
        req[2] = 1'b1; wr = 1'b0; addr = 32'h20;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (aok[2] !== exp_aok[k] || dok[2] !== exp_dok[k]) begin
                failures++;
                $display("FAIL accept_gap cycle=%0d addr_ok=%b data_ok=%b exp=%b/%b",
                         k, aok[2], dok[2], exp_aok[k], exp_dok[k]);
            end
            @(posedge clk); #1;
        end
        req[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int n = 0;
        send(1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
        repeat (6) @(posedge clk);
        #1;
        req[1] = 1'b1; wr = 1'b0; addr = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        req[1] = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin expq[i].delete(); accq[i].delete(); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dok[1]) n++;
        end
        checks++;
        if (n != 0) begin failures++; $display("FAIL reset_discard data_ok_count=%0d exp=0", n); end
        @(posedge clk); #1;
        send(1, 1'b0, 32'h40, 4'h0, 32'h0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dok[1] !== 1'b0) begin failures++; $display("FAIL reset_reload_early data_ok=%b exp=0", dok[1]); end
        end
        @(negedge clk);
        checks++;
        if (dok[1] !== 1'b1 || rd[1] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL reset_persist data_ok=%b rdata=%h exp=1/cafef00d", dok[1], rd[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_drain;
        repeat (10) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (expq[i].size() != 0) begin
                failures++; $display("FAIL missing_resp inst=%0d pending=%0d exp=0", i, expq[i].size());
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_byte_merge;
        test_wrap;
        test_backpressure;
        test_gap;
        test_reset_mid;
        test_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side endpoint of the data-memory port: the block that produces the load data the MEM stage consumes.
- Accepts SRAM-like requests from the pipeline's load/store path, keeps an internal word-organised data RAM, and returns in-order responses (data_ok/rdata) after a fixed latency.
- Supports a bounded number of outstanding requests and deterministic address-phase backpressure.
- Used as the data memory in simulation builds and as the reference responder for pipeline verification.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words
READ_LATENCY, 1, cycles from acceptance edge to data_ok (legal range >= 1)
DEPTH, 2, max outstanding accepted-but-unanswered requests (power of two, >= 1)
ACCEPT_GAP, 0, cycles addr_ok is forced low after each accepted request

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  1  request valid
wr  in  1  1 = store, 0 = load
size  in  2  0 = byte, 1 = half, 2 = word (informational; wstrb governs writes)
addr  in  32  byte address
wstrb  in  4  byte write enables, bit i -> wdata[8i+7:8i]
wdata  in  32  store data
addr_ok  out  1  request accepted this cycle when req & addr_ok
data_ok  out  1  response valid this cycle (single-cycle pulse, no backpressure)
rdata  out  32  full aligned word for loads, 0 for stores; valid only with data_ok

Behaviour:
- Reset: queue emptied, gap counter cleared; addr_ok=0, data_ok=0, rdata=0 while reset is high. RAM contents are not reset.
- Word index = addr[ADDR_WIDTH+1:2]. addr[1:0] and higher bits are ignored, so out-of-range addresses wrap. Misalignment is not checked.
- addr_ok = (count != DEPTH) & (gap_cnt == 0). It is independent of req and of a same-cycle pop, so a full queue popping this cycle still refuses.
- Acceptance (req & addr_ok at posedge):
  - Store: RAM bytes with wstrb[i]=1 are updated at that edge; the entry's rdata = 0.
  - Load: the entry's rdata = RAM word as it was before that edge.
  - Every accepted request pushes one entry {rdata, timer = READ_LATENCY-1}. gap_cnt loads ACCEPT_GAP.
- Timers: each valid entry's timer decrements every cycle and saturates at 0.
- Response: data_ok = (count != 0) & (timer[head] == 0); rdata = head rdata when data_ok, else 0. The head pops at the posedge where data_ok=1.
- Latency: a request accepted at edge E gets data_ok in the cycle right after E+READ_LATENCY-1 edges, unless older responses delay it. Responses are strictly in acceptance order, exactly one per request.
- Ordering: because the RAM is accessed at acceptance, a load accepted after a store to the same word sees the stored bytes. A load accepted in the same edge as nothing else sees prior contents.
- Simultaneous push and pop: count unchanged, both take effect. Pointers wrap modulo DEPTH.
- gap_cnt decrements each cycle while nonzero. With ACCEPT_GAP=0, back-to-back acceptance is allowed.
- Reset mid-operation: all pending entries are discarded. No data_ok is produced for them, and RAM writes already accepted persist.
- req with addr_ok=0 has no effect. The requester holds the request; the responder keeps no state for it.

Decomposition:
- Shared constants header: size encodings (SIZE_BYTE/HALF/WORD), request bundle width and field order, and the 32-bit data width.
- One sub-module, resp_queue:
  - DEPTH-entry FIFO of {rdata, timer} with per-entry saturating timers.
  - Outputs head_ready/head_data/full/empty.
- RAM array and accept/gap logic live in data_sram_responder.

Test Plan:
1. After reset, write word 0x12345678 at addr 0x10 with wstrb=4'hF, then load addr 0x10 (LATENCY=1) -> addr_ok high both cycles; store data_ok one cycle after acceptance with rdata=0; load data_ok next cycle with rdata=0x12345678.
2. Store wdata=0xAABBCCDD, wstrb=4'b0100 to 0x10 (prior 0x12345678), then load 0x12 -> rdata=0x12BB5678, full word returned.
3. DEPTH=2, READ_LATENCY=4, req held high with loads -> two acceptances on consecutive edges, then addr_ok=0 until the first data_ok pops. Third accept is on the pop edge+1; responses come in order, 4 cycles apart minimum from each accept.
4. ACCEPT_GAP=2, req held high -> addr_ok pattern 1,0,0,1,0,0; each accepted request yields exactly one data_ok.
5. Assert reset for one cycle while 2 loads are pending -> no data_ok afterwards. A following load of a word stored before the reset returns the stored value.
6. Load addr 0x1000_0010 with ADDR_WIDTH=10 -> returns the same word as addr 0x10 (wrap-around).
